// File: rtl/distri_ram_reader.sv
// distri_ram_reader
//   Streams a run of entries out of a distributed RAM (asynchronous read
//   port) onto a registered valid/ready interface with a last flag and a
//   completion pulse.
//
// Ports
//   clk_i       rising-edge clock
//   rst_ni      asynchronous active-low reset
//   start_i     start request, sampled only while idle
//   base_i      first entry index (< ENTRY_NUM)
//   len_i       number of entries to stream, 0..ENTRY_NUM
//   flush_i     abort the current stream (no effect while idle)
//   busy_o      high while a stream is in progress
//   done_o      one-cycle pulse when a stream completes normally
//   ram_addr_o  RAM read address (the internal pointer)
//   ram_data_i  combinational RAM read data for ram_addr_o
//   data_o      stream data (registered)
//   valid_o     stream valid (registered)
//   last_o      final word of the stream, qualified by valid_o
//   ready_i     downstream ready
module distri_ram_reader #(
   parameter int ENTRY_NUM = 32,
   parameter int XLEN      = 32,
   parameter int AWDTH     = $clog2(ENTRY_NUM)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [AWDTH-1:0] base_i,
   input  logic [AWDTH:0]   len_i,
   input  logic             flush_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [AWDTH-1:0] ram_addr_o,
   input  logic [XLEN-1:0]  ram_data_i,
   output logic [XLEN-1:0]  data_o,
   output logic             valid_o,
   output logic             last_o,
   input  logic             ready_i
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [AWDTH-1:0] PTR_MAX = AWDTH'(ENTRY_NUM - 1);
   localparam logic [AWDTH-1:0] PTR_ONE = AWDTH'(1);
   localparam logic [AWDTH:0]   REM_ONE = (AWDTH + 1)'(1);

   state_t            state_q, state_d;
   logic [AWDTH-1:0]  ptr_q, ptr_d;
   logic [AWDTH:0]    rem_q, rem_d;
   logic [XLEN-1:0]   data_q, data_d;
   logic              valid_q, valid_d;
   logic              last_q, last_d;
   logic              done_q, done_d;
   logic              load;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         rem_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      done_d  = 1'b0;
      load    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               if (len_i != '0) begin
                  state_d = READ;
                  ptr_d   = base_i;
                  rem_d   = len_i;
               end else begin
                  // Empty run: acknowledge with a done pulse, emit nothing.
                  done_d = 1'b1;
               end
            end
         end

         READ: begin
            // The output register refills whenever it is empty or being
            // drained this cycle, giving one word per cycle under ready.
            load = (rem_q != '0) && (!valid_q || ready_i);
            if (load) begin
               data_d  = ram_data_i;
               valid_d = 1'b1;
               last_d  = (rem_q == REM_ONE);
               ptr_d   = (ptr_q == PTR_MAX) ? '0 : ptr_q + PTR_ONE;
               rem_d   = rem_q - REM_ONE;
               if (rem_q == REM_ONE) begin
                  state_d = DRAIN;
               end
            end else if (valid_q && ready_i) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
            end
         end

         DRAIN: begin
            if (valid_q && ready_i) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Abort overrides all of the above outside IDLE; no completion pulse.
      if (flush_i && (state_q != IDLE)) begin
         state_d = IDLE;
         valid_d = 1'b0;
         last_d  = 1'b0;
         rem_d   = '0;
         done_d  = 1'b0;
      end
   end

   assign busy_o     = (state_q != IDLE);
   assign done_o     = done_q;
   assign ram_addr_o = ptr_q;
   assign data_o     = data_q;
   assign valid_o    = valid_q;
   assign last_o     = last_q;

endmodule

// File: tb/tb_distri_ram_reader.sv
module tb_distri_ram_reader;

   localparam int EN = 8;
   localparam int AW = 3;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] base;
   logic [AW:0]   len;
   logic          flush;
   logic          busy;
   logic          done;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_data;
   logic [31:0]   data;
   logic          valid;
   logic          last;
   logic          ready;

   // Distributed RAM model: synchronous write, asynchronous read.
   logic [31:0]   ram [EN];
   logic          we;
   logic [AW-1:0] waddr;
   logic [31:0]   wdata;

   always @(posedge clk) if (we) ram[waddr] <= wdata;
   assign ram_data = ram[ram_addr];

   int vectors;
   int miscompares;

   distri_ram_reader #(.ENTRY_NUM(EN), .XLEN(32)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .base_i(base),
      .len_i(len), .flush_i(flush), .busy_o(busy), .done_o(done),
      .ram_addr_o(ram_addr), .ram_data_i(ram_data), .data_o(data),
      .valid_o(valid), .last_o(last), .ready_i(ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic fill_ram(input bit rnd);
      for (int i = 0; i < EN; i++) begin
         @(negedge clk);
         we    = 1'b1;
         waddr = AW'(i);
         wdata = rnd ? $urandom : 32'h100 + i;
      end
      @(negedge clk);
      we = 1'b0;
   endtask

   // Starts a stream and consumes it. mode 0: ready held high, mode 1: random
   // ready. inj: issue a second start mid-stream (must be ignored).
   // Each word is checked against an expected queue built from the RAM image.
   task automatic run_stream(input int b, input int l, input int mode, input bit inj,
                             output int cnt, output logic [31:0] fw, output logic [31:0] lw);
      logic [31:0] q[$];
      int          cyc;
      int          tput;
      bit          seen;
      bit          fin;
      bit          pstall;
      bit          rdy;
      logic [31:0] pdata;
      logic        plast;
      logic [AW-1:0] paddr;
      cnt = 0; fw = '0; lw = '0;
      for (int i = 0; i < l; i++) q.push_back(ram[(b + i) % EN]);
      @(negedge clk);
      start = 1'b1; base = AW'(b); len = (AW+1)'(l); ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, (l != 0));
      if (l == 0) begin
         chk("len0_done", done, 1);
         chk("len0_valid", valid, 0);
         @(negedge clk);
         chk("len0_done_clear", done, 0);
         chk("len0_valid_after", valid, 0);
         return;
      end
      chk("addr_base", ram_addr, b);
      chk("valid_not_yet", valid, 0);
      ready = (mode == 0);
      @(negedge clk);
      cyc = 0; tput = 0; seen = 0; fin = 0; pstall = 0;
      while (!fin && cyc < 200) begin
         if (cyc == 0) chk("first_valid_latency", valid, 1);
         if (pstall) begin
            chk("stall_data", data, pdata);
            chk("stall_last", last, plast);
            chk("stall_addr", ram_addr, paddr);
         end
         chk("no_early_done", done, 0);
         chk("busy_during", busy, 1);
         if (valid) seen = 1;
         if (seen && q.size() > 0) tput++;
         if (inj && cyc == 2) begin
            start = 1'b1; base = '0; len = 4'd3;
         end else begin
            start = 1'b0;
         end
         rdy   = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         ready = rdy;
         if (valid && rdy) begin
            if (q.size() == 0) begin
               chk("extra_word", 1, 0);
            end else begin
               chk("word_data", data, q[0]);
               chk("word_last", last, (q.size() == 1));
               if (cnt == 0) fw = data;
               lw = data;
               void'(q.pop_front());
               cnt++;
               if (q.size() == 0) fin = 1;
            end
         end
         pstall = valid && !rdy;
         pdata  = data;
         plast  = last;
         paddr  = ram_addr;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      if (!fin) chk("stream_timeout", 0, 1);
      chk("done_pulse", done, 1);
      chk("busy_fall", busy, 0);
      chk("valid_after_last", valid, 0);
      ready = 1'b0;
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      if (mode == 0) chk("throughput", tput, l);
   endtask

   typedef struct {
      int          b;
      int          l;
      int          mode;
      logic [31:0] first;
      logic [31:0] lastw;
      int          cnt;
   } vec_t;

   vec_t        tbl[6];
   int          cnt;
   logic [31:0] fw;
   logic [31:0] lw;

   initial begin
      vectors = 0; miscompares = 0;
      rst_n = 1'b0; start = 1'b0; base = '0; len = '0; flush = 1'b0;
      ready = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
      tbl[0] = '{b: 2, l: 4, mode: 0, first: 32'h102, lastw: 32'h105, cnt: 4};
      tbl[1] = '{b: 6, l: 4, mode: 0, first: 32'h106, lastw: 32'h101, cnt: 4};
      tbl[2] = '{b: 0, l: 8, mode: 1, first: 32'h100, lastw: 32'h107, cnt: 8};
      tbl[3] = '{b: 7, l: 1, mode: 0, first: 32'h107, lastw: 32'h107, cnt: 1};
      tbl[4] = '{b: 5, l: 8, mode: 1, first: 32'h105, lastw: 32'h104, cnt: 8};
      tbl[5] = '{b: 3, l: 8, mode: 0, first: 32'h103, lastw: 32'h102, cnt: 8};

      #1;
      chk("rst_valid", valid, 0);
      chk("rst_last", last, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_data", data, 0);
      chk("rst_addr", ram_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      fill_ram(1'b0);

      // Table-driven streams over RAM[i] = 0x100 + i.
      for (int t = 0; t < 6; t++) begin
         run_stream(tbl[t].b, tbl[t].l, tbl[t].mode, 1'b0, cnt, fw, lw);
         chk("tbl_count", cnt, tbl[t].cnt);
         chk("tbl_first", fw, tbl[t].first);
         chk("tbl_lastword", lw, tbl[t].lastw);
      end

      // Empty run, then a start issued during a busy len=5 stream.
      run_stream(4, 0, 0, 1'b0, cnt, fw, lw);
      chk("len0_count", cnt, 0);
      run_stream(1, 5, 0, 1'b1, cnt, fw, lw);
      chk("restart_ignored_count", cnt, 5);
      chk("restart_ignored_last", lw, 32'h105);

      // Flush after the second handshake of a len=6 stream.
      @(negedge clk);
      start = 1'b1; base = '0; len = 4'd6; ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("flush_pre_data", data, 32'h102);
      flush = 1'b1; ready = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_valid", valid, 0);
      chk("flush_last", last, 0);
      chk("flush_busy", busy, 0);
      chk("flush_no_done", done, 0);
      @(negedge clk);
      chk("flush_no_done_late", done, 0);
      chk("flush_idle_valid", valid, 0);
      run_stream(0, 1, 0, 1'b0, cnt, fw, lw);
      chk("post_flush_count", cnt, 1);
      chk("post_flush_word", fw, 32'h100);

      // Flush while idle together with start: start wins.
      @(negedge clk);
      start = 1'b1; flush = 1'b1; base = 3'd2; len = 4'd1; ready = 1'b0;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      chk("start_beats_idle_flush", busy, 1);
      @(negedge clk);
      chk("idle_flush_word", data, 32'h102);
      chk("idle_flush_last", last, 1);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      chk("idle_flush_done", done, 1);

      // Write to the entry being read on the capture edge: old value seen.
      @(negedge clk);
      start = 1'b1; base = 3'd4; len = 4'd1;
      @(negedge clk);
      start = 1'b0; we = 1'b1; waddr = 3'd4; wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      we = 1'b0;
      chk("collision_old_value", data, 32'h104);
      chk("collision_valid", valid, 1);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      chk("collision_done", done, 1);
      run_stream(4, 1, 0, 1'b0, cnt, fw, lw);
      chk("collision_new_value", fw, 32'hDEAD_BEEF);

      // Asynchronous reset in the middle of a stalled stream.
      fill_ram(1'b0);
      @(negedge clk);
      start = 1'b1; base = '0; len = 4'd8; ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_reset_valid", valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", valid, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_done", done, 0);
      chk("async_rst_data", data, 0);
      chk("async_rst_addr", ram_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_idle", busy, 0);
      chk("post_reset_done", done, 0);
      run_stream(3, 5, 1, 1'b0, cnt, fw, lw);
      chk("post_reset_count", cnt, 5);
      chk("post_reset_first", fw, 32'h103);

      // Randomized streams over random RAM contents.
      fill_ram(1'b1);
      for (int r = 0; r < 24; r++) begin
         int b;
         int l;
         int m;
         b = $urandom_range(0, EN - 1);
         l = $urandom_range(0, EN);
         m = $urandom_range(0, 1);
         run_stream(b, l, m, 1'($urandom_range(0, 1)), cnt, fw, lw);
         chk("rand_count", cnt, l);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/distri_ram_reader.md
Name: distri_ram_reader

Overview:
- Read-side streaming engine for the core's distributed RAM (asynchronous read port, synchronous write port).
- On a start command it walks a run of entries from a base index, driving the RAM read address and capturing the combinational read data.
- Captured words are presented on a registered valid/ready stream with a last flag and a completion pulse.
- Used to dump tables, register snapshots or trace buffers held in distributed RAM to a downstream consumer.

Parameters:
- ENTRY_NUM, 32, number of RAM entries; any value >= 2, need not be a power of two
- XLEN, 32, data word width
- AWDTH, $clog2(ENTRY_NUM), RAM address width

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_ni  input  1  asynchronous active-low reset
- start_i  input  1  start request; sampled only in IDLE
- base_i  input  AWDTH  first entry index; must be < ENTRY_NUM
- len_i  input  AWDTH+1  number of entries to stream, 0..ENTRY_NUM
- flush_i  input  1  abort current stream
- busy_o  output  1  high whenever state != IDLE
- done_o  output  1  one-cycle pulse when a stream completes normally
- ram_addr_o  output  AWDTH  read address to the RAM read port
- ram_data_i  input  XLEN  combinational read data from the RAM
- data_o  output  XLEN  stream data (registered)
- valid_o  output  1  stream valid (registered)
- last_o  output  1  marks the final word of a stream; qualified by valid_o
- ready_i  input  1  downstream ready

Behaviour:
- Reset is asynchronous on rst_ni low. Required reset state:
  - state=IDLE
  - valid_o=0, last_o=0, done_o=0, busy_o=0
  - data_o=0, ram_addr_o=0
  - internal pointer=0, remaining count=0
- States:
  - IDLE -> READ when start_i=1 and len_i!=0. Latch base_i into the pointer and len_i into the remaining count.
  - IDLE with start_i=1 and len_i=0: pulse done_o in the next cycle, stay IDLE, emit no data.
  - READ -> DRAIN when the final word is loaded into the output register (remaining goes 1->0).
  - DRAIN -> IDLE when that last word handshakes (valid_o&ready_i). done_o=1 in that same edge's next cycle, i.e. a registered pulse of exactly one cycle.
- ram_addr_o equals the pointer register; the RAM read is combinational, so ram_data_i is valid in the same cycle.
- Load condition, in READ: load = (remaining!=0) && (!valid_o || ready_i). On load:
  - data_o <= ram_data_i; valid_o <= 1
  - last_o <= (remaining==1)
  - pointer advances; remaining decrements
- Pointer wrap: pointer == ENTRY_NUM-1 advances to 0 (modulo ENTRY_NUM, no power-of-two assumption).
- When valid_o&ready_i and no load occurs, valid_o <= 0 and last_o <= 0.
- Output stability: while valid_o=1 and ready_i=0, data_o and last_o hold steady and the pointer does not move.
- Timing:
  - Throughput is 1 word/cycle with ready_i held high.
  - start accepted at edge N: ram_addr_o=base from N; first valid_o=1 after edge N+1.
- start_i while busy_o=1 is ignored; no queuing.
- flush_i has priority over everything in any state except IDLE. On the next edge: valid_o=0, last_o=0, state=IDLE, remaining=0, no done_o. In IDLE, flush_i is a no-op.
- start_i and flush_i both high in IDLE: start wins, since flush is a no-op there.
- RAM write to the entry being read in the same cycle: the captured data is the pre-write value, as the RAM updates on the edge. No forwarding.
- len_i > ENTRY_NUM is illegal; the block simply wraps and rereads.
- Reset asserted mid-stream: all outputs drop to reset values immediately (asynchronously). No done_o.

Test Plan:
- ENTRY_NUM=8, RAM[i]=0x100+i, base=2, len=4, ready_i=1 -> data_o 0x102,0x103,0x104,0x105 on 4 consecutive cycles; last_o only with 0x105; done_o one cycle after; busy_o falls with it.
- base=6, len=4 -> addresses 6,7,0,1; data 0x106,0x107,0x100,0x101 (wrap check).
- len=8, ready_i toggling 1,0,0,1,... randomly -> exactly 8 words in order 0x100..0x107 (base=0); data_o/last_o stable during stalls; no drop or duplicate.
- len=0 start -> done_o pulse, valid_o never asserts; a second start during a len=5 stream -> ignored, exactly 5 words.
- flush_i asserted after the 2nd handshake of a len=6 stream -> valid_o=0 next cycle, busy_o=0, no done_o; a following start with base=0, len=1 yields 0x100 with last_o=1.
- rst_ni pulled low mid-stream, asynchronously (not on a clock edge) -> valid_o, busy_o and done_o are 0 immediately; after release the block is in IDLE and a new stream works.
